wb_csr_ctrl: RTL and testbench

//  Writeback-stage controller for the 5-stage RV32 core. It drives the WB data-source select
//  (ALU pass-through / load data / CSR), owns the user counters (cycle, instret, load-stall)

---
 rtl/wb_pkg.sv | 22 ++
 rtl/csr_counter.sv | 35 +++
 rtl/wb_csr_ctrl.sv | 94 +++++++++
 tb/tb_wb_csr_ctrl.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared types and CSR addresses for the writeback-stage controller.
package wb_pkg;

  typedef enum logic [2:0] {
    WB_ALU  = 3'b000,
    WB_LOAD = 3'b110,
    WB_CSR  = 3'b111
  } wb_src_e;

  typedef enum logic {
    IDLE,
    WAIT_LOAD
  } wb_state_e;

  localparam logic [11:0] CSR_CYCLE    = 12'hC00;
  localparam logic [11:0] CSR_CYCLEH   = 12'hC80;
  localparam logic [11:0] CSR_INSTRET  = 12'hC02;
  localparam logic [11:0] CSR_INSTRETH = 12'hC82;
  localparam logic [11:0] CSR_LSTALL   = 12'hC03;
  localparam logic [11:0] CSR_LSTALLH  = 12'hC83;

endpackage

// File: rtl/csr_counter.sv
// Free-running user counter: async active-low clear, increment enable, wraps silently.
module csr_counter #(
  parameter int unsigned CNT_W = 64
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             inc_i,
  input  logic             ld_i,
  input  logic [CNT_W-1:0] ld_val_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_d, cnt_q;

  // Load seeds the count (debug / unit bring-up); it overrides increment.
  always_comb begin
    cnt_d = cnt_q;
    if (ld_i) begin
      cnt_d = ld_val_i;
    end else if (inc_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/wb_csr_ctrl.sv
// Writeback-stage controller: WB source select, load-wait stall, RF write gating,
// and the cycle / instret / load-stall user counters behind the CSR read mux.
module wb_csr_ctrl
  import wb_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_W,
  input  logic            is_load_W,
  input  logic            is_csr_W,
  input  logic            reg_wen_req_W,
  input  logic [4:0]      rd_W,
  input  logic [11:0]     csr_addr_W,
  input  logic            dm_rvalid,
  output logic [2:0]      WB_data_src_W,
  output logic [XLEN-1:0] CSR_cyc,
  output logic            rf_we,
  output logic [4:0]      rf_waddr,
  output logic            wb_stall,
  output logic            retire
);

  wb_state_e        state_d, state_q;
  wb_src_e          src;
  logic [CNT_W-1:0] cyc_cnt, inst_cnt, lst_cnt;
  logic [XLEN-1:0]  csr_rd;

  // Stall is combinational so a load whose data is already valid costs no cycles.
  assign wb_stall = rst & valid_W & is_load_W & ~dm_rvalid;
  assign retire   = rst & valid_W & ~wb_stall;
  assign rf_we    = retire & reg_wen_req_W & (rd_W != 5'd0);
  assign rf_waddr = rd_W;

  always_comb begin
    src = WB_ALU;
    if (is_load_W) begin
      src = WB_LOAD;
    end else if (is_csr_W) begin
      src = WB_CSR;
    end
    WB_data_src_W = rst ? src : WB_ALU;
  end

  // Leaving WAIT_LOAD on any stall drop also covers valid_W falling mid-wait.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:      if (wb_stall) state_d = WAIT_LOAD;
      WAIT_LOAD: if (!wb_stall) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  csr_counter #(.CNT_W(CNT_W)) u_cycle (
    .clk_i(clk), .rst_ni(rst), .inc_i(1'b1),
    .ld_i(1'b0), .ld_val_i('0), .cnt_o(cyc_cnt)
  );

  csr_counter #(.CNT_W(CNT_W)) u_instret (
    .clk_i(clk), .rst_ni(rst), .inc_i(retire),
    .ld_i(1'b0), .ld_val_i('0), .cnt_o(inst_cnt)
  );

  csr_counter #(.CNT_W(CNT_W)) u_lstall (
    .clk_i(clk), .rst_ni(rst), .inc_i(wb_stall),
    .ld_i(1'b0), .ld_val_i('0), .cnt_o(lst_cnt)
  );

  always_comb begin
    csr_rd = '0;
    unique case (csr_addr_W)
      CSR_CYCLE:    csr_rd = cyc_cnt[0 +: XLEN];
      CSR_CYCLEH:   csr_rd = cyc_cnt[XLEN +: XLEN];
      CSR_INSTRET:  csr_rd = inst_cnt[0 +: XLEN];
      CSR_INSTRETH: csr_rd = inst_cnt[XLEN +: XLEN];
      CSR_LSTALL:   csr_rd = lst_cnt[0 +: XLEN];
      CSR_LSTALLH:  csr_rd = lst_cnt[XLEN +: XLEN];
      default:      csr_rd = '0;
    endcase
    CSR_cyc = rst ? csr_rd : '0;
  end

endmodule

// File: tb/tb_wb_csr_ctrl.sv
// Directed bench for wb_csr_ctrl plus a standalone csr_counter for wrap/carry.
module tb_wb_csr_ctrl;
  import wb_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        valid_W = 1'b0, is_load_W = 1'b0, is_csr_W = 1'b0, reg_wen_req_W = 1'b0;
  logic [4:0]  rd_W = '0;
  logic [11:0] csr_addr_W = CSR_CYCLE;
  logic        dm_rvalid = 1'b0;
  logic [2:0]  WB_data_src_W;
  logic [31:0] CSR_cyc;
  logic        rf_we, wb_stall, retire;
  logic [4:0]  rf_waddr;

  logic        c_rst_n = 1'b0, c_inc = 1'b0, c_ld = 1'b0;
  logic [63:0] c_ld_val = '0, c_cnt;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  always #5 clk = ~clk;

  wb_csr_ctrl #(.XLEN(32), .CNT_W(64)) dut (
    .clk(clk), .rst(rst), .valid_W(valid_W), .is_load_W(is_load_W),
    .is_csr_W(is_csr_W), .reg_wen_req_W(reg_wen_req_W), .rd_W(rd_W),
    .csr_addr_W(csr_addr_W), .dm_rvalid(dm_rvalid), .WB_data_src_W(WB_data_src_W),
    .CSR_cyc(CSR_cyc), .rf_we(rf_we), .rf_waddr(rf_waddr), .wb_stall(wb_stall),
    .retire(retire)
  );

  csr_counter #(.CNT_W(64)) u_cnt (
    .clk_i(clk), .rst_ni(c_rst_n), .inc_i(c_inc), .ld_i(c_ld),
    .ld_val_i(c_ld_val), .cnt_o(c_cnt)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd_csr(input logic [11:0] a, input string tag, input logic [63:0] exp);
    csr_addr_W = a;
    #1;
    check(tag, 64'(CSR_cyc), exp);
  endtask

  initial begin
    // Reset state, with inputs that would otherwise stall/retire
    valid_W = 1'b1; is_load_W = 1'b1; reg_wen_req_W = 1'b1; rd_W = 5'd3;
    tick(); #1;
    check("rst_stall",  64'(wb_stall), 0);
    check("rst_retire", 64'(retire), 0);
    check("rst_rf_we",  64'(rf_we), 0);
    check("rst_src",    64'(WB_data_src_W), 0);
    check("rst_csr",    64'(CSR_cyc), 0);
    valid_W = 1'b0; is_load_W = 1'b0; reg_wen_req_W = 1'b0; rd_W = '0;
    tick();
    rst = 1'b1;

    // 1. Ten idle cycles
    for (int i = 0; i < 10; i++) begin
      tick();
      check("idle_rf_we", 64'(rf_we), 0);
    end
    rd_csr(CSR_CYCLE,   "t1_cycle",   10);
    rd_csr(CSR_CYCLEH,  "t1_cycleh",  0);
    rd_csr(CSR_INSTRET, "t1_instret", 0);
    rd_csr(CSR_LSTALL,  "t1_lstall",  0);
    rd_csr(12'hC01,     "t1_badaddr", 0);

    // 2. ALU op to x5; instret read is pre-increment
    valid_W = 1'b1; reg_wen_req_W = 1'b1; rd_W = 5'd5;
    rd_csr(CSR_INSTRET, "t2_inst_pre", 0);
    check("t2_src",    64'(WB_data_src_W), 64'(WB_ALU));
    check("t2_rf_we",  64'(rf_we), 1);
    check("t2_waddr",  64'(rf_waddr), 5);
    check("t2_retire", 64'(retire), 1);
    tick();
    rd_csr(CSR_INSTRET, "t2_inst_post", 1);
    rd_csr(CSR_CYCLE,   "t2_cycle",     11);
    // CSR read of instret does not see its own retirement
    is_csr_W = 1'b1; rd_W = 5'd6;
    rd_csr(CSR_INSTRET, "t2_csr_self", 1);
    check("t2_src_csr", 64'(WB_data_src_W), 64'(WB_CSR));
    tick();
    // Load beats CSR; data already valid -> no stall
    is_load_W = 1'b1; dm_rvalid = 1'b1; #1;
    check("t2_src_prio", 64'(WB_data_src_W), 64'(WB_LOAD));
    check("t2_nostall",  64'(wb_stall), 0);
    check("t2_ld_ret",   64'(retire), 1);
    tick();  // cycle=13 instret=3

    // 3. Load to x7, data arrives after 3 cycles
    is_csr_W = 1'b0; rd_W = 5'd7; dm_rvalid = 1'b0; #1;
    for (int i = 0; i < 3; i++) begin
      check("t3_stall", 64'(wb_stall), 1);
      check("t3_rf_we", 64'(rf_we), 0);
      check("t3_retire", 64'(retire), 0);
      tick();
      check("t3_state", 64'(dut.state_q), 64'(WAIT_LOAD));
    end
    dm_rvalid = 1'b1;
    rd_csr(CSR_LSTALL, "t3_lstall", 3);
    check("t3_stall_end", 64'(wb_stall), 0);
    check("t3_rf_we_end", 64'(rf_we), 1);
    check("t3_waddr",     64'(rf_waddr), 7);
    tick();  // cycle=17 instret=4
    valid_W = 1'b0; is_load_W = 1'b0; dm_rvalid = 1'b0;
    check("t3_idle", 64'(dut.state_q), 64'(IDLE));
    rd_csr(CSR_INSTRET, "t3_instret", 4);
    rd_csr(CSR_CYCLE,   "t3_cycle",   17);

    // 4. Write to x0
    valid_W = 1'b1; rd_W = 5'd0; #1;
    check("t4_retire", 64'(retire), 1);
    check("t4_rf_we",  64'(rf_we), 0);
    tick();  // instret=5 cycle=18

    // valid drops mid-wait
    is_load_W = 1'b1; rd_W = 5'd9; #1;
    check("vd_stall", 64'(wb_stall), 1);
    tick();  // lstall=4 cycle=19
    valid_W = 1'b0; #1;
    check("vd_stall0", 64'(wb_stall), 0);
    check("vd_rf_we",  64'(rf_we), 0);
    tick();
    check("vd_idle", 64'(dut.state_q), 64'(IDLE));
    rd_csr(CSR_INSTRET, "vd_instret", 5);
    rd_csr(CSR_LSTALL,  "vd_lstall",  4);
    rd_csr(CSR_LSTALLH, "vd_lstallh", 0);
    rd_csr(CSR_INSTRETH, "vd_instreth", 0);

    // 5. Counter carry and wrap on a standalone instance
    c_rst_n = 1'b1; c_ld = 1'b1; c_ld_val = 64'h0000_0000_FFFF_FFFF;
    tick();
    c_ld = 1'b0; c_inc = 1'b1;
    tick();
    check("t5_lo", 64'(c_cnt[31:0]), 0);
    check("t5_hi", 64'(c_cnt[63:32]), 1);
    c_ld = 1'b1; c_ld_val = '1;
    tick();
    c_ld = 1'b0;
    tick();
    check("t5_wrap", c_cnt, 0);
    c_inc = 1'b0;
    tick();
    check("t5_hold", c_cnt, 0);

    // 6. Reset pulse during WAIT_LOAD
    csr_addr_W = CSR_CYCLE; valid_W = 1'b1; is_load_W = 1'b1; dm_rvalid = 1'b0;
    tick();
    check("t6_wait", 64'(dut.state_q), 64'(WAIT_LOAD));
    rst = 1'b0; #1;
    check("t6_stall_async", 64'(wb_stall), 0);
    check("t6_state_async", 64'(dut.state_q), 64'(IDLE));
    valid_W = 1'b0; is_load_W = 1'b0;
    tick();
    rst = 1'b1;
    rd_csr(CSR_CYCLE,   "t6_cycle",   0);
    rd_csr(CSR_INSTRET, "t6_instret", 0);
    rd_csr(CSR_LSTALL,  "t6_lstall",  0);
    tick();
    rd_csr(CSR_CYCLE, "t6_cycle_run", 1);
    check("t6_idle", 64'(dut.state_q), 64'(IDLE));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
